// File: rtl/l2_trigger_pkg.sv
// rtl/l2_trigger_pkg.sv - shared state encoding, reset weights and saturating add for the L2 trigger MAC
package l2_trigger_pkg;

  typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} l2_state_e;

  localparam logic signed [7:0] L2_B_RST = -8'sd24;

  function automatic logic signed [7:0] L2_W_RST(input int idx);
    case (idx)
      0:       return 8'sd127;
      1:       return -8'sd128;
      2:       return -8'sd128;
      default: return 8'sd0;
    endcase
  endfunction

  // Operands arrive sign-extended from acc_w bits; result is clamped to the acc_w signed range.
  function automatic logic signed [63:0] l2_sat_add(input logic signed [63:0] a,
                                                    input logic signed [63:0] b,
                                                    input int acc_w);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    s  = {a[63], a} + {b[63], b};
    hi = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
    lo = -hi - 65'sd1;
    if (s > hi)      return hi[63:0];
    else if (s < lo) return lo[63:0];
    else             return s[63:0];
  endfunction

endpackage

// File: rtl/l2_trigger_mac_if.sv
// rtl/l2_trigger_mac_if.sv - event, weight-write and result signals of the L2 trigger MAC
interface l2_trigger_mac_if #(
  parameter int N_IN  = 3,
  parameter int IN_W  = 16,
  parameter int W_W   = 8,
  parameter int ACC_W = 32
);
  logic                         in_valid;
  logic                         in_ready;
  logic [N_IN*IN_W-1:0]         in_data;
  logic                         wt_we;
  logic [$clog2(N_IN+1)-1:0]    wt_addr;
  logic [W_W-1:0]               wt_data;
  logic                         wt_drop;
  logic                         out_valid;
  logic                         out_ready;
  logic                         trigger;
  logic [ACC_W-1:0]             score;

  modport slave (
    input  in_valid, in_data, wt_we, wt_addr, wt_data, out_ready,
    output in_ready, wt_drop, out_valid, trigger, score
  );

  modport master (
    output in_valid, in_data, wt_we, wt_addr, wt_data, out_ready,
    input  in_ready, wt_drop, out_valid, trigger, score
  );
endinterface

// File: rtl/l2_weight_regfile.sv
// rtl/l2_weight_regfile.sv - N_IN weights plus bias, synchronous write, all entries readable combinationally
module l2_weight_regfile
  import l2_trigger_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int W_W  = 8,
  parameter int AW   = $clog2(N_IN+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_addr,
  input  logic [W_W-1:0]           i_wdata,
  output logic [(N_IN+1)*W_W-1:0]  o_regs
);

  logic signed [W_W-1:0] r_regs [N_IN+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= N_IN; i++)
        r_regs[i] <= (i == N_IN) ? W_W'(L2_B_RST) : W_W'(L2_W_RST(i));
    end else if (i_we && (i_addr <= AW'(N_IN))) begin
      r_regs[i_addr] <= i_wdata;
    end
  end

  genvar g;
  for (g = 0; g <= N_IN; g++) begin : g_rd
    assign o_regs[g*W_W +: W_W] = r_regs[g];
  end

endmodule

// File: rtl/l2_trigger_mac.sv
// rtl/l2_trigger_mac.sv - sequential weighted-sum trigger, one MAC per cycle, then bias and threshold
// Define L2_SCORE_SAT_EN to saturate each accumulate instead of wrapping.
module l2_trigger_mac
  import l2_trigger_pkg::*;
#(
  parameter int                     N_IN   = 3,
  parameter int                     IN_W   = 16,
  parameter int                     W_W    = 8,
  parameter int                     ACC_W  = 32,
  parameter logic signed [ACC_W-1:0] THRESH = '0
) (
  input  logic            clk,
  input  logic            rst,
  l2_trigger_mac_if.slave bus
);

  localparam int AW = $clog2(N_IN+1);
  localparam int PW = IN_W + W_W;

  l2_state_e                   r_state;
  logic [AW-1:0]               r_idx;
  logic [N_IN*IN_W-1:0]        r_data;
  logic [(N_IN+1)*W_W-1:0]     r_wsnap;
  logic signed [ACC_W-1:0]     r_acc;
  logic signed [ACC_W-1:0]     r_score;
  logic                        r_trigger;
  logic                        r_out_valid;
  logic                        r_in_ready;
  logic                        r_wt_drop;

  logic                        w_wt_we;
  logic [(N_IN+1)*W_W-1:0]     w_regs;
  logic signed [IN_W-1:0]      w_n [N_IN];
  logic signed [W_W-1:0]       w_w [N_IN];
  logic signed [W_W-1:0]       w_b;
  logic signed [PW-1:0]        w_prod;
  logic signed [ACC_W-1:0]     w_addend;
  logic signed [ACC_W-1:0]     w_sum;

  assign w_wt_we = bus.wt_we && (r_state == IDLE);

  l2_weight_regfile #(.N_IN(N_IN), .W_W(W_W), .AW(AW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wt_we),
    .i_addr  (bus.wt_addr),
    .i_wdata (bus.wt_data),
    .o_regs  (w_regs)
  );

  // Weights are snapshotted at capture so a same-cycle write only affects later events.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      w_n[i] = r_data[i*IN_W +: IN_W];
      w_w[i] = r_wsnap[i*W_W +: W_W];
    end
    w_b      = r_wsnap[N_IN*W_W +: W_W];
    w_prod   = w_n[r_idx] * w_w[r_idx];
    w_addend = (r_state == BIAS) ? ACC_W'(w_b) : ACC_W'(w_prod);
`ifdef L2_SCORE_SAT_EN
    w_sum    = ACC_W'(l2_sat_add(64'(r_acc), 64'(w_addend), ACC_W));
`else
    w_sum    = r_acc + w_addend;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_data      <= '0;
      r_wsnap     <= '0;
      r_acc       <= '0;
      r_score     <= '0;
      r_trigger   <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_wt_drop   <= 1'b0;
    end else begin
      r_wt_drop <= bus.wt_we && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (bus.in_valid && r_in_ready) begin
            r_data     <= bus.in_data;
            r_wsnap    <= w_regs;
            r_acc      <= '0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_sum;
          if (r_idx == AW'(N_IN-1)) r_state <= BIAS;
          else                      r_idx   <= r_idx + 1'b1;
        end
        BIAS: begin
          r_acc       <= w_sum;
          r_score     <= w_sum;
          r_trigger   <= (w_sum > THRESH);
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.score     = r_score;
  assign bus.trigger   = r_trigger;
  assign bus.wt_drop   = r_wt_drop;

endmodule

// File: tb/tb_l2_trigger_mac.sv
// tb/tb_l2_trigger_mac.sv - directed and randomized checks of l2_trigger_mac against a behavioural model
module tb_l2_trigger_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_trigger_mac_if #(.N_IN(3), .IN_W(16), .W_W(8), .ACC_W(32)) bus ();
  l2_trigger_mac #(.N_IN(3), .IN_W(16), .W_W(8), .ACC_W(32), .THRESH(0)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  // Narrow-accumulator instance with threshold at the bias value
  l2_trigger_mac_if #(.N_IN(3), .IN_W(16), .W_W(8), .ACC_W(24)) bus2 ();
  l2_trigger_mac #(.N_IN(3), .IN_W(16), .W_W(8), .ACC_W(24), .THRESH(-24)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model: weights as integers, event progress as an edge count since acceptance
  int     mw [4];
  bit     m_idle, m_ready, m_valid, m_drop, m_trig;
  longint m_score, m_pend;
  int     m_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sx16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sx8(input logic [7:0] v);
    return longint'($signed(v));
  endfunction

  function automatic void model_reset();
    mw = '{127, -128, -128, -24};
    m_idle = 1; m_ready = 0; m_valid = 0; m_drop = 0;
    m_trig = 0; m_score = 0; m_pend = 0; m_t = 0;
  endfunction

  function automatic void model_edge();
    bit hs, was_valid;
    if (rst) begin
      model_reset();
      return;
    end
    hs        = bus.in_valid && m_ready;
    was_valid = m_valid;
    m_drop    = bus.wt_we && !m_idle;
    if (m_idle) begin
      m_ready = 1;
      if (hs) begin
        m_pend = sx16(bus.in_data[15:0]) * mw[0] + sx16(bus.in_data[31:16]) * mw[1]
               + sx16(bus.in_data[47:32]) * mw[2] + mw[3];
        m_idle = 0; m_ready = 0; m_t = 0;
      end
      if (bus.wt_we) mw[bus.wt_addr] = int'(sx8(bus.wt_data));
    end else begin
      m_t++;
      if (m_t == 4) begin
        m_valid = 1; m_score = m_pend; m_trig = (m_pend > 0);
      end else if (was_valid && bus.out_ready) begin
        m_valid = 0; m_idle = 1; m_ready = 1;
      end
    end
  endfunction

  task automatic compare();
    check("in_ready",  longint'(bus.in_ready),  longint'(m_ready));
    check("out_valid", longint'(bus.out_valid), longint'(m_valid));
    check("wt_drop",   longint'(bus.wt_drop),   longint'(m_drop));
    check("score",     longint'($signed(bus.score)), m_score);
    check("trigger",   longint'(bus.trigger),   longint'(m_trig));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic send(input int a, input int b, input int c);
    int k;
    k = 0;
    while (!bus.in_ready && k < 50) begin tick(); k++; end
    check("send_timeout", longint'(k >= 50), 0);
    bus.in_valid = 1'b1;
    bus.in_data  = {16'(c), 16'(b), 16'(a)};
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin tick(); lat++; end
    check("valid_timeout", longint'(lat >= 50), 0);
  endtask

  task automatic wait_valid2();
    int k;
    k = 0;
    while (!bus2.out_valid && k < 50) begin tick(); k++; end
    check("valid2_timeout", longint'(k >= 50), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    model_reset();
    bus.in_valid = 0; bus.in_data = '0; bus.wt_we = 0; bus.wt_addr = '0;
    bus.wt_data = '0; bus.out_ready = 1;
    bus2.in_valid = 0; bus2.in_data = '0; bus2.wt_we = 0; bus2.wt_addr = '0;
    bus2.wt_data = '0; bus2.out_ready = 1;

    rst = 1; tick(); tick();
    check("rst_in_ready", longint'(bus.in_ready), 0);
    check("rst_score",    longint'($signed(bus.score)), 0);
    rst = 0; tick();

    // Default weights: 100*127 + 10*-128 + 20*-128 - 24
    send(100, 10, 20);
    wait_valid(lat);
    check("t1_latency", lat, 4);
    check("t1_score", longint'($signed(bus.score)), 8836);
    check("t1_trigger", longint'(bus.trigger), 1);
    tick();

    send(0, 0, 0);
    wait_valid(lat);
    check("t2_score", longint'($signed(bus.score)), -24);
    check("t2_trigger", longint'(bus.trigger), 0);
    tick();

    // Backpressure: result must hold while a second event waits
    bus.out_ready = 0;
    send(5, 6, 7);
    wait_valid(lat);
    check("t3_score", longint'($signed(bus.score)), -1053);
    bus.in_valid = 1; bus.in_data = {16'd3, 16'd2, 16'd1};
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_valid", longint'(bus.out_valid), 1);
      check("t3_hold_score", longint'($signed(bus.score)), -1053);
    end
    bus.out_ready = 1;
    tick();
    check("t3_ready_after_accept", longint'(bus.in_ready), 1);
    tick();
    check("t3_second_taken", longint'(bus.in_ready), 0);
    bus.in_valid = 0;
    wait_valid(lat);
    check("t3_second_score", longint'($signed(bus.score)), -537);
    tick();

    // Write outside IDLE is dropped, same write in IDLE lands
    send(0, 0, 0);
    tick();
    bus.wt_we = 1; bus.wt_addr = 2'd3; bus.wt_data = 8'd100;
    tick();
    bus.wt_we = 0;
    check("t4_drop_pulse", longint'(bus.wt_drop), 1);
    wait_valid(lat);
    check("t4_bias_kept", longint'($signed(bus.score)), -24);
    tick();
    bus.wt_we = 1; bus.wt_addr = 2'd3; bus.wt_data = 8'd100;
    tick();
    bus.wt_we = 0;
    send(0, 0, 0);
    wait_valid(lat);
    check("t4_bias_new", longint'($signed(bus.score)), 100);
    check("t4_trigger", longint'(bus.trigger), 1);
    tick();

    // Write coincident with acceptance: event sees old w0
    while (!bus.in_ready) tick();
    bus.in_valid = 1; bus.in_data = {16'd0, 16'd0, 16'd1};
    bus.wt_we = 1; bus.wt_addr = 2'd0; bus.wt_data = 8'd1;
    tick();
    bus.in_valid = 0; bus.wt_we = 0;
    wait_valid(lat);
    check("t4_coincident_old", longint'($signed(bus.score)), 227);
    tick();
    send(1, 0, 0);
    wait_valid(lat);
    check("t4_coincident_new", longint'($signed(bus.score)), 101);
    tick();

    // Reset in the middle of MAC restores weights
    send(1, 1, 1);
    tick();
    rst = 1; tick(); rst = 0;
    check("t6_out_valid", longint'(bus.out_valid), 0);
    send(1, 1, 1);
    wait_valid(lat);
    check("t6_restored", longint'($signed(bus.score)), -153);
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 48'({$urandom(), $urandom()});
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.wt_we     = ($urandom_range(0, 7) == 0);
      bus.wt_addr   = 2'($urandom_range(0, 3));
      bus.wt_data   = 8'($urandom());
      rst           = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0; bus.in_valid = 0; bus.wt_we = 0; bus.out_ready = 1;
    tick(); tick();

    // Narrow accumulator instance
    bus2.in_valid = 1; bus2.in_data = '0;
    tick();
    bus2.in_valid = 0;
    wait_valid2();
    check("t2_narrow_score", longint'($signed(bus2.score)), -24);
    check("t2_strict_gt", longint'(bus2.trigger), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus2.wt_we = 1; bus2.wt_addr = 2'(i); bus2.wt_data = (i < 3) ? 8'h80 : 8'h00;
      tick();
    end
    bus2.wt_we = 0;
    bus2.in_valid = 1; bus2.in_data = {3{16'h8000}};
    tick();
    bus2.in_valid = 0;
    wait_valid2();
`ifdef L2_SCORE_SAT_EN
    check("t5_sat_score", longint'($signed(bus2.score)), 8388607);
    check("t5_sat_trigger", longint'(bus2.trigger), 1);
`else
    check("t5_wrap_score", longint'($signed(bus2.score)), -4194304);
    check("t5_wrap_trigger", longint'(bus2.trigger), 0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
